// File: rtl/orpsoc_wb_pkg.sv
// Shared Wishbone definitions for the memory arbiter.
// Cycle-type codes and the arbiter FSM encoding.
package orpsoc_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Bus bundle between NM Wishbone masters, the arbiter and one slave.
// slave: arbiter side; master: environment (masters plus memory).
interface wb_mem_arbiter_if #(
  parameter int NM = 3,
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM-1:0]    m_we_i;
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM*2-1:0]  m_bte_i;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NM-1:0]    m_rty_o;

  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [SW-1:0]    s_sel_o;
  logic             s_we_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic             s_cyc_o;
  logic             s_stb_o;
  logic [DW-1:0]    s_dat_i;
  logic             s_ack_i;
  logic             s_err_i;
  logic             s_rty_i;

  logic [NM-1:0]    grant_o;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i,
    input  m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o,
    output s_cti_o, s_bte_o, s_cyc_o, s_stb_o,
    output grant_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i,
    output m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o,
    input  s_cti_o, s_bte_o, s_cyc_o, s_stb_o,
    input  grant_o
  );

endinterface

// File: rtl/wb_arb_rr_pick.sv
// Round-robin picker: rotate requests past the last owner,
// take the lowest set bit, rotate the one-hot result back.
module wb_arb_rr_pick #(
  parameter int NM = 3,
  parameter int LW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [LW-1:0] last,
  output logic [NM-1:0] pick
);

  logic [NM-1:0] rot;
  logic [NM-1:0] low;
  int            sh;

  always_comb begin
    sh   = int'(last) + 1;
    rot  = '0;
    low  = '0;
    pick = '0;
    for (int i = 0; i < NM; i++)
      rot[i] = req[(i + sh) % NM];
    for (int i = NM - 1; i >= 0; i--)
      if (rot[i]) begin
        low    = '0;
        low[i] = 1'b1;
      end
    for (int i = 0; i < NM; i++)
      pick[(i + sh) % NM] = low[i];
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone arbiter, grant held for the whole cyc envelope.
// Define WB_ARB_TIMEOUT_EN to add the hung-slave watchdog.
module wb_mem_arbiter
  import orpsoc_wb_pkg::*;
#(
  parameter int NM             = 3,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic             wb_clk_i,
  input logic             wb_rst_i,
  wb_mem_arbiter_if.slave bus
);

  localparam int LW = $clog2(NM);
  localparam int SW = DW / 8;

  arb_state_t    state, state_d;
  logic [NM-1:0] grant, grant_d, pick;
  logic [LW-1:0] last, last_d, own;
  logic          owned, own_cyc, own_stb, timeout;

  wb_arb_rr_pick #(
    .NM(NM),
    .LW(LW)
  ) u_pick (
    .req (bus.m_cyc_i),
    .last(last),
    .pick(pick)
  );

  always_comb begin
    own = '0;
    for (int i = 0; i < NM; i++)
      if (grant[i]) own = LW'(i);
  end

  // reset kills the envelope in the same cycle it is raised
  assign owned   = (state == ARB_OWNED) && !wb_rst_i;
  assign own_cyc = bus.m_cyc_i[own];
  assign own_stb = bus.m_stb_i[own];

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        term;

  assign term = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      wd_cnt <= '0;
    else if (bus.s_stb_o && !term)
      wd_cnt <= wd_cnt + 16'd1;
    else
      wd_cnt <= '0;
  end

  assign timeout = (state == ARB_OWNED) &&
                   (wd_cnt == 16'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ARB_IDLE;
      grant <= '0;
      last  <= LW'(NM - 1);
    end else begin
      state <= state_d;
      grant <= grant_d;
      last  <= last_d;
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    last_d  = last;
    unique case (state)
      ARB_IDLE:
        if (|bus.m_cyc_i) begin
          state_d = ARB_OWNED;
          grant_d = pick;
        end
      ARB_OWNED:
        if (!own_cyc || timeout) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          last_d  = own;
        end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.s_adr_o = bus.m_adr_i[own*AW +: AW];
    bus.s_dat_o = bus.m_dat_i[own*DW +: DW];
    bus.s_sel_o = bus.m_sel_i[own*SW +: SW];
    bus.s_we_o  = bus.m_we_i[own];
    bus.s_cti_o = bus.m_cti_i[own*3 +: 3];
    bus.s_bte_o = bus.m_bte_i[own*2 +: 2];
    bus.s_cyc_o = owned && own_cyc && !timeout;
    bus.s_stb_o = owned && own_cyc && own_stb && !timeout;
    bus.m_ack_o = owned ? grant & {NM{bus.s_ack_i}} : '0;
    bus.m_err_o = owned ? grant & {NM{bus.s_err_i | timeout}} : '0;
    bus.m_rty_o = owned ? grant & {NM{bus.s_rty_i}} : '0;
    bus.m_dat_o = bus.s_dat_i;
    bus.grant_o = grant;
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a round-robin ownership model.
module tb_wb_mem_arbiter;
  import orpsoc_wb_pkg::*;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  int   len[NM];

  always #5 clk = ~clk;

  wb_mem_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

  wb_mem_arbiter #(
    .NM(NM),
    .AW(AW),
    .DW(DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ownership model: -1 idle, else owning master
  int own_m  = -1;
  int last_m = NM - 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      own_m  <= -1;
      last_m <= NM - 1;
    end else if (own_m < 0) begin
      for (int k = NM; k >= 1; k--)
        if (bus.m_cyc_i[(last_m + k) % NM]) own_m <= (last_m + k) % NM;
    end else if (!bus.m_cyc_i[own_m]) begin
      last_m <= own_m;
      own_m  <= -1;
    end
  end

  always @(negedge clk) begin : model_chk
    logic [NM-1:0] g;
    logic [NM-1:0] one;
    logic          oc, os;
    if (chk_en) begin
      one = 1;
      g   = (own_m < 0) ? '0 : one << own_m;
      oc  = (own_m >= 0) ? bus.m_cyc_i[own_m] : 1'b0;
      os  = (own_m >= 0) ? bus.m_stb_i[own_m] : 1'b0;
      check("grant", bus.grant_o, g);
      check("s_cyc", bus.s_cyc_o, oc);
      check("s_stb", bus.s_stb_o, oc & os);
      check("m_ack", bus.m_ack_o, bus.s_ack_i ? g : '0);
      check("m_err", bus.m_err_o, bus.s_err_i ? g : '0);
      check("m_rty", bus.m_rty_o, bus.s_rty_i ? g : '0);
      check("m_dat", bus.m_dat_o, bus.s_dat_i);
      if (own_m >= 0) begin
        check("s_adr", bus.s_adr_o, bus.m_adr_i[own_m*AW +: AW]);
        check("s_dat", bus.s_dat_o, bus.m_dat_i[own_m*DW +: DW]);
        check("s_sel", bus.s_sel_o, bus.m_sel_i[own_m*SW +: SW]);
        check("s_we", bus.s_we_o, bus.m_we_i[own_m]);
        check("s_cti", bus.s_cti_o, bus.m_cti_i[own_m*3 +: 3]);
        check("s_bte", bus.s_bte_o, bus.m_bte_i[own_m*2 +: 2]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.m_we_i  = '0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_cti_i = '0;
    bus.m_bte_i = '0;
    bus.s_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    bus.s_rty_i = 1'b0;
    for (int i = 0; i < NM; i++) len[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic req(input int i, input logic [31:0] adr,
                     input logic [2:0] cti);
    bus.m_cyc_i[i]          = 1'b1;
    bus.m_stb_i[i]          = 1'b1;
    bus.m_adr_i[i*AW +: AW] = adr;
    bus.m_sel_i[i*SW +: SW] = '1;
    bus.m_cti_i[i*3 +: 3]   = cti;
  endtask

  task automatic rand_fields(input int i);
    bus.m_stb_i[i]          = 1'($urandom_range(1));
    bus.m_we_i[i]           = 1'($urandom_range(1));
    bus.m_adr_i[i*AW +: AW] = AW'($urandom);
    bus.m_dat_i[i*DW +: DW] = DW'($urandom);
    bus.m_sel_i[i*SW +: SW] = SW'($urandom);
    bus.m_cti_i[i*3 +: 3]   = 3'($urandom_range(7));
    bus.m_bte_i[i*2 +: 2]   = 2'($urandom_range(3));
  endtask

  task automatic rand_cycle();
    for (int i = 0; i < NM; i++) begin
      if (len[i] > 0) begin
        len[i]--;
        if (len[i] == 0) bus.m_cyc_i[i] = 1'b0;
        else rand_fields(i);
      end else if ($urandom_range(3) == 0) begin
        len[i]         = $urandom_range(1, 6);
        bus.m_cyc_i[i] = 1'b1;
        rand_fields(i);
      end
    end
    bus.s_dat_i = DW'($urandom);
    bus.s_ack_i = 1'($urandom_range(1));
    bus.s_err_i = ($urandom_range(15) == 0);
    bus.s_rty_i = ($urandom_range(15) == 0);
  endtask

  initial begin : main
    int acks;
    idle_all();
    chk_en = 1'b1;

    // reset state, even with a slave ack present
    bus.s_ack_i = 1'b1;
    bus.m_cyc_i = '1;
    bus.m_stb_i = '1;
    tick();
    check("rst_grant", bus.grant_o, 0);
    check("rst_cyc", bus.s_cyc_o, 0);
    check("rst_ack", bus.m_ack_o, 0);
    do_reset();

    // single classic read from master 1
    req(1, 32'h100, CTI_CLASSIC);
    #1;
    check("t1_nocyc", bus.s_cyc_o, 0);
    tick();
    check("t1_cyc", bus.s_cyc_o, 1);
    check("t1_adr", bus.s_adr_o, 32'h100);
    bus.s_ack_i = 1'b1;
    #1;
    check("t1_ack", bus.m_ack_o, 3'b010);
    tick();
    idle_all();
    tick();

    // simultaneous requests after reset
    do_reset();
    for (int i = 0; i < NM; i++) req(i, 32'(i * 16), CTI_CLASSIC);
    for (int k = 0; k < NM; k++) begin
      tick();
      check("t2_order", bus.grant_o, 3'b001 << k);
      bus.m_cyc_i[k] = 1'b0;
      tick();
      check("t2_gap", bus.s_cyc_o, 0);
    end

    // 8-beat burst not split by a competing request
    do_reset();
    req(0, 32'h2000, CTI_INC);
    req(2, 32'h3000, CTI_CLASSIC);
    tick();
    check("t3_grant", bus.grant_o, 3'b001);
    bus.s_ack_i = 1'b1;
    acks = 0;
    for (int b = 0; b < 8; b++) begin
      bus.m_cti_i[2:0]  = (b == 7) ? CTI_EOB : CTI_INC;
      bus.m_adr_i[31:0] = 32'h2000 + 32'(b * 4);
      #1;
      if (bus.m_ack_o == 3'b001) acks++;
      check("t3_hold", bus.grant_o, 3'b001);
      tick();
    end
    bus.m_cyc_i[0] = 1'b0;
    bus.s_ack_i    = 1'b0;
    check("t3_acks", acks, 8);
    tick();
    check("t3_gap", bus.grant_o, 0);
    tick();
    check("t3_next", bus.grant_o, 3'b100);
    idle_all();
    tick();

    // continuous owner keeps the bus, then rotation
    do_reset();
    req(1, 32'h40, CTI_CLASSIC);
    tick();
    check("t4_grant", bus.grant_o, 3'b010);
    req(0, 32'h80, CTI_CLASSIC);
    repeat (5) begin
      tick();
      check("t4_keep", bus.grant_o, 3'b010);
    end
    bus.m_cyc_i[1] = 1'b0;
    tick();
    check("t4_gap", bus.grant_o, 0);
    req(1, 32'h40, CTI_CLASSIC);
    tick();
    check("t4_rr", bus.grant_o, 3'b001);
    idle_all();
    tick();

    // asynchronous reset during beat 3 of a burst
    do_reset();
    req(1, 32'h500, CTI_INC);
    tick();
    bus.s_ack_i = 1'b1;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("t5_cyc", bus.s_cyc_o, 0);
    check("t5_grant", bus.grant_o, 0);
    check("t5_ack", bus.m_ack_o, 0);
    idle_all();
    tick();
    rst = 1'b0;
    req(0, 32'h600, CTI_CLASSIC);
    req(1, 32'h700, CTI_CLASSIC);
    tick();
    check("t5_first", bus.grant_o, 3'b001);
    idle_all();
    tick();

    // slave that never acks
    do_reset();
    req(2, 32'hdead0, CTI_CLASSIC);
`ifdef WB_ARB_TIMEOUT_EN
    begin
      int err_at;
      logic [NM-1:0] g17;
      chk_en = 1'b0;
      err_at = -1;
      g17    = '1;
      tick();
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (bus.m_err_o[2] && err_at < 0) err_at = k;
        if (k == 17) g17 = bus.grant_o;
      end
      check("t6_err_at", err_at, 16);
      check("t6_release", g17, 0);
    end
`else
    tick();
    repeat (1000) tick();
    check("t6_held", bus.grant_o, 3'b100);
    check("t6_cyc", bus.s_cyc_o, 1);
`endif
    do_reset();
    chk_en = 1'b1;

    // random traffic against the model
    repeat (3000) begin
      rand_cycle();
      tick();
    end
    idle_all();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
